// File: rtl/risc_pkg.sv
// Shared definitions for the RISC controller: opcodes, FSM states,
// ALU operation codes, instruction field positions and the NOP encoding.
package risc_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOT  = 3'b011,
        OP_CMP  = 3'b100,
        OP_MOV  = 3'b101,
        OP_NOP  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_WRITEBACK = 3'b011,
        ST_HALT      = 3'b100
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RA_MSB  = 9;
    localparam int RA_LSB  = 7;
    localparam int RB_MSB  = 6;
    localparam int RB_LSB  = 4;

    localparam logic [15:0] NOP_INSTR = 16'hC000;

    // Extract the opcode field of an instruction word as the enum type.
    function automatic opcode_e get_opcode(input logic [15:0] ir);
        return opcode_e'(ir[OPC_MSB:OPC_LSB]);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: selects the ALU operation and tells the
// controller whether the instruction writes rd and/or loads the flags.
module instr_decoder
    import risc_pkg::*;
#(
    parameter int FLAGS_ON_MOV = 0
) (
    input  opcode_e    opcode,
    output logic [1:0] alu_op,
    output logic       alu_b_zero,
    output logic       writes_rd,
    output logic       sets_flags
);

    // Map each opcode to its ALU control and side-effect flags.
    always_comb begin
        alu_op     = ALU_ADD;
        alu_b_zero = 1'b0;
        writes_rd  = 1'b0;
        sets_flags = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_op     = ALU_ADD;
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_SUB: begin
                alu_op     = ALU_SUB;
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_AND: begin
                alu_op     = ALU_AND;
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_NOT: begin
                alu_op     = ALU_NOT;
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_CMP: begin
                alu_op     = ALU_SUB;
                sets_flags = 1'b1;
            end
            OP_MOV: begin
                // MOV is rd = ra + 0
                alu_op     = ALU_ADD;
                alu_b_zero = 1'b1;
                writes_rd  = 1'b1;
                sets_flags = (FLAGS_ON_MOV != 0);
            end
            default: begin
                alu_op     = ALU_ADD;
                alu_b_zero = 1'b0;
                writes_rd  = 1'b0;
                sets_flags = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/risc_controller.sv
// Multi-cycle controller for a small 16-bit RISC datapath:
// FETCH -> DECODE -> EXECUTE -> WRITEBACK, with a terminal HALT state.
module risc_controller
    import risc_pkg::*;
#(
    parameter int FLAGS_ON_MOV = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  rf_ra_addr,
    output logic [2:0]  rf_rb_addr,
    output logic [1:0]  alu_op,
    output logic        alu_b_zero,
    input  logic [2:0]  alu_status,
    output logic        rf_we,
    output logic [2:0]  rf_wa,
    output logic [2:0]  flags,
    output logic        halted
);

    state_e      state_r;
    state_e      next_state_s;
    logic [15:0] ir_r;
    logic [2:0]  flags_r;
    opcode_e     opcode_s;
    logic        writes_rd_s;
    logic        sets_flags_s;
    logic        unused_ir_bits_s;

    assign opcode_s         = get_opcode(ir_r);
    // Low nibble of the instruction word carries no information.
    assign unused_ir_bits_s = ^ir_r[3:0] ^ writes_rd_s;

    instr_decoder #(
        .FLAGS_ON_MOV (FLAGS_ON_MOV)
    ) u_decoder (
        .opcode     (opcode_s),
        .alu_op     (alu_op),
        .alu_b_zero (alu_b_zero),
        .writes_rd  (writes_rd_s),
        .sets_flags (sets_flags_s)
    );

    // Register fields feed the datapath directly, so they stay stable
    // from DECODE until the next accept.
    assign rf_ra_addr = ir_r[RA_MSB:RA_LSB];
    assign rf_rb_addr = ir_r[RB_MSB:RB_LSB];
    assign rf_wa      = ir_r[RD_MSB:RD_LSB];
    assign flags      = flags_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction register: captured only on a handshake in FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_r <= NOP_INSTR;
        end else if (state_r == ST_FETCH && instr_valid) begin
            ir_r <= instr;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Flags load from the ALU at the end of EXECUTE for flag-setting ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= 3'b000;
        end else if (state_r == ST_EXECUTE && sets_flags_s) begin
            flags_r <= alu_status;
        end else begin
            flags_r <= flags_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (instr_valid) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opcode_s)
                    OP_NOP:  next_state_s = ST_FETCH;
                    OP_HALT: next_state_s = ST_HALT;
                    default: next_state_s = ST_EXECUTE;
                endcase
            end
            ST_EXECUTE: begin
                if (opcode_s == OP_CMP) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: next_state_s = ST_FETCH;
            ST_HALT:      next_state_s = ST_HALT;
            default:      next_state_s = ST_FETCH;
        endcase
    end

    // Handshake/strobe outputs decoded from state; reset masks them at once
    // so an in-flight write is dropped in the very cycle reset rises.
    always_comb begin
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        halted      = 1'b0;
        if (!reset) begin
            instr_ready = (state_r == ST_FETCH);
            rf_we       = (state_r == ST_WRITEBACK);
            halted      = (state_r == ST_HALT);
        end else begin
            instr_ready = 1'b0;
            rf_we       = 1'b0;
            halted      = 1'b0;
        end
    end

endmodule

// File: doc/risc_controller.md
RISC_CONTROLLER -- requirements
Module: risc_controller

Interface
REQ-001 SHALL have parameter FLAGS_ON_MOV, default 0; when 1, MOV also updates flags.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port instr_valid  in  1  upstream instruction present.
REQ-005 SHALL have port instr  in  16  instruction word; sampled only on accept.
REQ-006 SHALL have port instr_ready  out  1  controller can accept an instruction.
REQ-007 SHALL have port rf_ra_addr  out  3  register-file read address A, i.e. ALU a_in source.
REQ-008 SHALL have port rf_rb_addr  out  3  register-file read address B, i.e. ALU b_in source.
REQ-009 SHALL have port alu_op  out  2  ALU opcode: 00 ADD, 01 SUB, 10 AND, 11 NOT a.
REQ-010 SHALL have port alu_b_zero  out  1  force ALU b_in to 16'h0000, used for MOV.
REQ-011 SHALL have port alu_status  in  3  ALU status {overflow, negative, zero}.
REQ-012 SHALL have port rf_we  out  1  register-file write strobe; write data is the ALU out.
REQ-013 SHALL have port rf_wa  out  3  register-file write address.
REQ-014 SHALL have port flags  out  3  registered {V,N,Z}.
REQ-015 SHALL have port halted  out  1  HALT executed.

Function
REQ-016 SHALL decode instr fields as: [15:13] opcode, [12:10] rd, [9:7] ra, [6:4] rb, [3:0] ignored.
REQ-017 SHALL implement opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 CMP (SUB, flags only), 101 MOV (rd=ra via ADD with alu_b_zero=1), 110 NOP, 111 HALT.
REQ-018 SHALL implement states FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
REQ-019 SHALL assert instr_ready only in FETCH while reset is low.
REQ-020 SHALL, in FETCH, when instr_valid=1, latch instr into IR and go to DECODE; otherwise stay in FETCH.
REQ-021 SHALL, in DECODE, transition: NOP -> FETCH; HALT -> HALT; all other opcodes -> EXECUTE.
REQ-022 SHALL, in EXECUTE, transition: CMP -> FETCH; all other opcodes -> WRITEBACK.
REQ-023 SHALL, at the end of EXECUTE, load flags from alu_status for ADD/SUB/AND/NOT/CMP, and for MOV only if FLAGS_ON_MOV=1.
REQ-024 SHALL, in WRITEBACK, assert rf_we=1 for exactly one cycle with rf_wa=IR.rd, then go to FETCH.
REQ-025 SHALL drive rf_ra_addr, rf_rb_addr, alu_op, alu_b_zero and rf_wa from IR in every state, held stable from DECODE through WRITEBACK.
REQ-026 SHALL deassert rf_we in all states other than WRITEBACK.
REQ-027 SHALL give ALU instructions a latency of 4 cycles, accept to next instr_ready; CMP 3 cycles; NOP 2 cycles.
REQ-028 SHALL, in HALT, hold halted=1 and instr_ready=0, ignore instr_valid, and leave only via reset.
REQ-029 SHALL leave flags unchanged by NOP, HALT and rejected (not-ready) instructions.
REQ-030 SHALL allow rd equal to ra or rb; the write occurs in WRITEBACK after operands were used, with no hazard handling required.

Reset
REQ-031 SHALL, while reset=1, force: state FETCH, IR=16'hC000 (NOP), flags=3'b000, rf_we=0, halted=0, instr_ready=0.
REQ-032 SHALL, on reset mid-instruction (any state, including WRITEBACK and HALT), abort without writing and without updating flags.
REQ-033 SHALL raise instr_ready in the first cycle after reset deasserts.

Structure
REQ-034 SHALL place the opcode enum, state enum, ALU op constants, instruction field positions and the NOP encoding in shared package risc_pkg.
REQ-035 SHALL use one combinational sub-module, instr_decoder, mapping IR to alu_op, alu_b_zero, writes_rd and sets_flags.

Verification
REQ-036 SHALL cover ADD 0x0290 (rd=0, ra=5, rb=1) with alu_status=000 -> rf_we high exactly at accept+3, rf_wa=0, flags=000, instr_ready at accept+4.
REQ-037 SHALL cover CMP with alu_status=001 -> flags=001, rf_we never asserted, instr_ready at accept+3.
REQ-038 SHALL cover MOV with FLAGS_ON_MOV=0 and alu_status=110 -> alu_b_zero=1 in EXECUTE, flags unchanged, one write.
REQ-039 SHALL cover HALT followed by instr_valid held high -> halted=1, instr_ready=0 indefinitely; reset -> halted=0, ready the next cycle.
REQ-040 SHALL cover reset asserted during WRITEBACK -> rf_we=0 that cycle, flags=000, state FETCH.
REQ-041 SHALL cover back-to-back instr_valid=1 stream of NOP, ADD, NOP -> accepts at cycles 0, 2, 6.
